// File: rtl/io_mmio_port.sv
// Memory-mapped I/O port: register window, output latch, debounced inputs, event FIFO.
// Optional IO_MMIO_IRQ_EN adds an IRQ mask register and a registered irq output.
module io_mmio_port #(
  parameter logic [15:0] IO_BASE   = 16'hFFF0,
  parameter int          DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] proc_dout,
  input  logic        we,
  output logic [15:0] proc_din,
  output logic        hit,
  input  logic [3:0]  io_in,
`ifdef IO_MMIO_IRQ_EN
  output logic        irq,
`endif
  output logic [3:0]  io_out
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [2:0] off;
  logic       wr;
  logic       wr_out;
  logic       wr_stat;
  logic       wr_pop;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] cand;
  logic [3:0] deb;
  logic [7:0] cnt;
  logic       accept;

  logic [3:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       do_pop;
  logic       do_push;
  logic       drop;
  logic [3:0] head;

  logic       chg;
  logic       ovf;

  assign hit     = addr[15:3] == IO_BASE[15:3];
  assign off     = addr[2:0];
  assign wr      = we & hit;
  assign wr_out  = wr & (off == 3'd1);
  assign wr_stat = wr & (off == 3'd2);
  assign wr_pop  = wr & (off == 3'd3);

  assign accept = (sync2 == cand) && (cand != deb) && (cnt == DB_LAST);

  assign full    = count == 3'd4;
  assign empty   = count == 3'd0;
  assign do_pop  = wr_pop & ~empty;
  // A pop on a full FIFO frees the slot the coincident push lands in.
  assign do_push = accept & (~full | do_pop);
  assign drop    = accept & full & ~do_pop;
  assign head    = empty ? 4'h0 : mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'h0;
      sync2 <= 4'h0;
      cand  <= 4'h0;
      deb   <= 4'h0;
      cnt   <= 8'h0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= 8'h0;
      end else if (cand != deb) begin
        if (cnt == DB_LAST) deb <= cand;
        else cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= cand;
        wp      <= wp + 2'd1;
      end
      if (do_pop) rp <= rp + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  // Set beats write-1-to-clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chg    <= 1'b0;
      ovf    <= 1'b0;
      io_out <= 4'h0;
    end else begin
      chg <= accept | (chg & ~(wr_stat & proc_dout[0]));
      ovf <= drop | (ovf & ~(wr_stat & proc_dout[2]));
      if (wr_out) io_out <= proc_dout[3:0];
    end
  end

`ifdef IO_MMIO_IRQ_EN
  logic [1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (wr & (off == 3'd4)) mask <= proc_dout[1:0];
      irq <= (chg & mask[0]) | (ovf & mask[1]);
    end
  end
`endif

  always_comb begin
    proc_din = 16'h0000;
    if (hit) begin
      case (off)
        3'd0:    proc_din = {12'h000, deb};
        3'd1:    proc_din = {12'h000, io_out};
        3'd2:    proc_din = {13'h0000, ovf, ~empty, chg};
        3'd3:    proc_din = {12'h000, head};
`ifdef IO_MMIO_IRQ_EN
        3'd4:    proc_din = {14'h0000, mask};
`endif
        default: proc_din = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_io_mmio_port.sv
// Directed bench for io_mmio_port: bus vector table plus debounce/FIFO sequences.
// Covers the IRQ path too when IO_MMIO_IRQ_EN is defined.
module tb_io_mmio_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] proc_dout;
  logic        we;
  logic [15:0] proc_din;
  logic        hit;
  logic [3:0]  io_in;
  logic [3:0]  io_out;
`ifdef IO_MMIO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] B = 16'hFFF0;

  io_mmio_port #(.IO_BASE(16'hFFF0), .DB_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .proc_dout(proc_dout),
    .we(we),
    .proc_din(proc_din),
    .hit(hit),
    .io_in(io_in),
`ifdef IO_MMIO_IRQ_EN
    .irq(irq),
`endif
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        hit;
    logic [15:0] din;
    logic [3:0]  out;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    proc_dout = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a,
                    input logic [15:0] exp);
    addr = a;
    we = 1'b0;
    #1;
    check(name, proc_din, exp);
  endtask

  initial begin
    vt[0]  = '{1'b1, B + 16'd1, 16'h1235, 1'b1, 16'h0000, 4'h5};
    vt[1]  = '{1'b0, B + 16'd1, 16'h0000, 1'b1, 16'h0005, 4'h5};
    vt[2]  = '{1'b1, B - 16'd1, 16'h0009, 1'b0, 16'h0000, 4'h5};
    vt[3]  = '{1'b0, B - 16'd1, 16'h0000, 1'b0, 16'h0000, 4'h5};
    vt[4]  = '{1'b0, B,         16'h0000, 1'b1, 16'h000b, 4'h5};
    vt[5]  = '{1'b0, B + 16'd5, 16'h0000, 1'b1, 16'h0000, 4'h5};
    vt[6]  = '{1'b1, B + 16'd5, 16'hffff, 1'b1, 16'h0000, 4'h5};
    vt[7]  = '{1'b0, B + 16'd7, 16'h0000, 1'b1, 16'h0000, 4'h5};
    vt[8]  = '{1'b0, B + 16'd4, 16'h0000, 1'b1, 16'h0000, 4'h5};
    vt[9]  = '{1'b1, B + 16'd1, 16'h000a, 1'b1, 16'h0000, 4'ha};
    vt[10] = '{1'b0, B + 16'd1, 16'h0000, 1'b1, 16'h000a, 4'ha};
    vt[11] = '{1'b0, 16'h0008,  16'h0000, 1'b0, 16'h0000, 4'ha};
    vt[12] = '{1'b0, B + 16'd2, 16'h0000, 1'b1, 16'h0000, 4'ha};

    reset = 1'b1;
    addr = 16'h0000;
    proc_dout = 16'h0000;
    we = 1'b0;
    io_in = 4'hb;
    tick(3);

    // Nonzero input held through reset is logged once after release.
    reset = 1'b0;
    check("rst_io_out", {12'h0, io_out}, 16'h0000);
    rd("rst_in", B, 16'h0000);
    tick(6);
    rd("in_edge6", B, 16'h0000);
    tick(1);
    rd("in_edge7", B, 16'h000b);
    rd("rst_status", B + 16'd2, 16'h0003);
    rd("rst_fifo", B + 16'd3, 16'h000b);
    bus_wr(B + 16'd3, 16'h0000);
    bus_wr(B + 16'd2, 16'h0001);
    rd("clean_status", B + 16'd2, 16'h0000);

    for (int i = 0; i < 13; i++) begin
      addr = vt[i].a;
      proc_dout = vt[i].d;
      we = 1'b0;
      #1;
      check($sformatf("vec%0d_hit", i), {15'h0, hit}, {15'h0, vt[i].hit});
      if (vt[i].wr) begin
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
      end else begin
        check($sformatf("vec%0d_din", i), proc_din, vt[i].din);
      end
      check($sformatf("vec%0d_out", i), {12'h0, io_out}, {12'h0, vt[i].out});
    end

    io_in = 4'h0;
    tick(9);
    bus_wr(B + 16'd3, 16'h0000);
    bus_wr(B + 16'd2, 16'h0001);
    rd("pre_glitch_status", B + 16'd2, 16'h0000);
    io_in = 4'h6;
    tick(3);
    io_in = 4'h0;
    tick(12);
    rd("glitch_in", B, 16'h0000);
    rd("glitch_status", B + 16'd2, 16'h0000);

    for (int v = 1; v <= 6; v++) begin
      io_in = 4'(v);
      tick(9);
    end
    rd("six_in", B, 16'h0006);
    rd("six_status", B + 16'd2, 16'h0007);
    bus_wr(B + 16'd2, 16'h0005);
    rd("w1c_status", B + 16'd2, 16'h0002);
    for (int k = 1; k <= 4; k++) begin
      rd($sformatf("pop%0d", k), B + 16'd3, 16'(k));
      bus_wr(B + 16'd3, 16'h0000);
    end
    rd("drained_status", B + 16'd2, 16'h0000);
    bus_wr(B + 16'd3, 16'h0000);
    rd("empty_pop_status", B + 16'd2, 16'h0000);
    rd("empty_fifo", B + 16'd3, 16'h0000);

    for (int v = 7; v <= 10; v++) begin
      io_in = 4'(v);
      tick(9);
    end
    rd("full_status", B + 16'd2, 16'h0003);
    bus_wr(B + 16'd2, 16'h0005);
    io_in = 4'hc;
    tick(6);
    addr = B + 16'd3;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd("coin_in", B, 16'h000c);
    rd("coin_status", B + 16'd2, 16'h0003);
    rd("coin_h0", B + 16'd3, 16'h0008);
    bus_wr(B + 16'd3, 16'h0000);
    rd("coin_h1", B + 16'd3, 16'h0009);
    bus_wr(B + 16'd3, 16'h0000);
    rd("coin_h2", B + 16'd3, 16'h000a);
    bus_wr(B + 16'd3, 16'h0000);
    rd("coin_h3", B + 16'd3, 16'h000c);
    bus_wr(B + 16'd3, 16'h0000);
    rd("coin_end", B + 16'd2, 16'h0001);
    bus_wr(B + 16'd2, 16'h0001);

`ifdef IO_MMIO_IRQ_EN
    bus_wr(B + 16'd4, 16'h0001);
    rd("mask_rd", B + 16'd4, 16'h0001);
    io_in = 4'h3;
    tick(7);
    rd("irq_chg", B + 16'd2, 16'h0003);
    check("irq_lag", {15'h0, irq}, 16'h0000);
    tick(1);
    check("irq_set", {15'h0, irq}, 16'h0001);
    bus_wr(B + 16'd2, 16'h0001);
    check("irq_hold", {15'h0, irq}, 16'h0001);
    tick(1);
    check("irq_clr", {15'h0, irq}, 16'h0000);
    bus_wr(B + 16'd3, 16'h0000);
`endif

    // Reset lands while the debounce counter sits at 2.
    io_in = 4'h5;
    tick(5);
    reset = 1'b1;
    tick(1);
    rd("mid_rst_in", B, 16'h0000);
    rd("mid_rst_status", B + 16'd2, 16'h0000);
    rd("mid_rst_fifo", B + 16'd3, 16'h0000);
    check("mid_rst_out", {12'h0, io_out}, 16'h0000);
`ifdef IO_MMIO_IRQ_EN
    rd("mid_rst_mask", B + 16'd4, 16'h0000);
    check("mid_rst_irq", {15'h0, irq}, 16'h0000);
`endif
    reset = 1'b0;
    tick(7);
    rd("post_rst_in", B, 16'h0005);
    rd("post_rst_status", B + 16'd2, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_mmio_port.md
Name: io_mmio_port

Overview:
- Memory-mapped I/O responder on the processor data bus; the peripheral end of the bus the processor drives with addr/proc_dout/we.
- Claims a small register window. Returns read data on proc_din.
- Drives io_out from a writable register.
- Synchronizes and debounces io_in, and logs each debounced input change into a 4-entry event FIFO with sticky status flags.
- Sits beside data memory in the system top; the top muxes proc_din using hit.

Parameters:
- IO_BASE, 16'hFFF0, base address of the register window (low 3 bits must be 0).
- DB_CYCLES, 4, consecutive stable cycles required before a synchronized input is accepted (1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- addr  in  16  processor address
- proc_dout  in  16  processor write data
- we  in  1  processor write strobe; one cycle per store
- proc_din  out  16  read data to processor (combinational)
- hit  out  1  addr within window IO_BASE..IO_BASE+7 (combinational)
- io_in  in  4  asynchronous external inputs
- io_out  out  4  external outputs (registered)

Behaviour:
- Register map (offset = addr[2:0], valid when addr[15:3]==IO_BASE[15:3]):
  - 0 IN: read {12'h0, deb}.
  - 1 OUT: read/write, bits 3:0. Write sets io_out <= proc_dout[3:0] at the next edge.
  - 2 STATUS: read {13'h0, ovf, nonempty, chg}. Write is write-1-to-clear: bit0 clears chg, bit2 clears ovf.
  - 3 FIFO: read {12'h0, head} (0 when empty). Any write pops one entry.
  - 4 IRQ_MASK: see Optional Feature.
  - 5..7: read 0, writes ignored.
- proc_din = 16'h0000 when hit=0. Reads have no side effects.
- Writes take effect at a rising edge with we=1 and hit=1. Each such cycle is one write.
- Input path: 2-flop synchronizer, then candidate register cand and counter cnt (8 bits).
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - Otherwise, if cand != deb: when cnt == DB_CYCLES-1, deb <= cand, set chg, push cand; else cnt++.
  - Net latency: deb updates at the (3+DB_CYCLES)th rising edge after io_in first takes a stable new value.
  - A glitch shorter than DB_CYCLES+1 cycles never reaches deb.
- FIFO: depth 4, 4-bit entries, 2-bit read/write pointers plus 3-bit count.
  - Push when full: entry dropped, ovf set.
  - Pop when empty: no effect.
  - Simultaneous push and pop: both occur (count unchanged). When not full, the pushed entry lands correctly; when full, pop frees a slot first, so the push is accepted and ovf is not set.
- chg/ovf set and clear in the same cycle: set wins.
- Reset (any cycle, including mid-debounce or mid-FIFO):
  - io_out=0, deb=0, cand=0, sync flops=0, cnt=0.
  - FIFO empty, pointers 0, chg=0, ovf=0, IRQ_MASK=0.
  - Consequence: a nonzero io_in held through reset logs one event after release.

Optional Feature:
- Macro IO_MMIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, registered).
  - Offset 4 IRQ_MASK is read/write, bits 1:0: bit0 enables chg, bit1 enables ovf.
  - irq <= (chg & mask[0]) | (ovf & mask[1]), i.e. one cycle after the flag/mask changes. irq resets to 0.
- Undefined: no irq port; offset 4 reads 0 and ignores writes.

Test Plan:
- Reset with io_in=4'hb, DB_CYCLES=4:
  - io_out=0, IN reads 0 immediately after reset.
  - IN reads 16'h000b at edge 7 after release.
  - STATUS=16'h0003, FIFO reads 16'h000b.
- Write 16'h1235 to IO_BASE+1 -> io_out=4'h5 next cycle; read of IO_BASE+1 returns 16'h0005. Write to IO_BASE-1 -> hit=0, io_out unchanged, proc_din=0.
- io_in 4'h0 -> 4'h6 for 3 cycles -> back to 4'h0 -> deb stays 0, no FIFO push, chg stays 0.
- Six stable changes (1,2,3,4,5,6) with no pops:
  - FIFO holds 1,2,3,4; STATUS=16'h0007.
  - Write 16'h0005 to STATUS -> 16'h0002.
  - Four pops return 1,2,3,4, then STATUS=0; a fifth pop is harmless.
- Debounce accept coincident with FIFO pop on a full FIFO -> count stays 4, new entry at tail, ovf stays 0.
- IO_MMIO_IRQ_EN build: mask=16'h0001, input change -> irq=1 one cycle after chg; write 1 to STATUS bit0 -> irq=0 one cycle later. Assert reset during cnt=2 -> all state zero next cycle.
